// File: rtl/four_output_demux_reg.sv
// Registered 1-to-4 demultiplexer with valid/ready handshakes.
// Steers one word to channel a/b/c/d (or broadcasts to all) into per-channel output registers.
module four_output_demux_reg #(
    parameter int unsigned INPUT_LENGTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [INPUT_LENGTH-1:0] in_data,
    input  logic [1:0]              in_sel,
    input  logic                    in_bcast,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [INPUT_LENGTH-1:0] out_a,
    output logic [INPUT_LENGTH-1:0] out_b,
    output logic [INPUT_LENGTH-1:0] out_c,
    output logic [INPUT_LENGTH-1:0] out_d,
    output logic [3:0]              out_valid,
    input  logic [3:0]              out_ready
);

    localparam int unsigned N_CH = 4;

    logic [INPUT_LENGTH-1:0] data_q [N_CH];
    logic [N_CH-1:0]         can_acc;
    logic [N_CH-1:0]         load_set;
    logic                    xfer;

    // A channel can take a word if it is empty or being drained this cycle.
    always_comb begin
        can_acc  = ~out_valid | out_ready;
        load_set = 4'b0001 << in_sel;
        in_ready = can_acc[in_sel];
        if (in_bcast) begin
            load_set = 4'b1111;
            in_ready = &can_acc;
        end
        xfer = in_valid && in_ready;
    end

    // Per-channel load has priority over drain; broadcast is all-or-nothing via in_ready.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= '0;
            for (int i = 0; i < N_CH; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (xfer && load_set[i]) begin
                    data_q[i]    <= in_data;
                    out_valid[i] <= 1'b1;
                end else if (out_valid[i] && out_ready[i]) begin
                    out_valid[i] <= 1'b0;
                end
            end
        end
    end

    assign out_a = data_q[0];
    assign out_b = data_q[1];
    assign out_c = data_q[2];
    assign out_d = data_q[3];

endmodule

// File: tb/tb_four_output_demux_reg.sv
// Bench for four_output_demux_reg: directed vector table followed by a randomized
// phase checked against a channel-occupancy reference model.
module tb_four_output_demux_reg;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] in_data;
    logic [1:0] in_sel;
    logic       in_bcast;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_a, out_b, out_c, out_d;
    logic [3:0] out_valid;
    logic [3:0] out_ready;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    four_output_demux_reg #(.INPUT_LENGTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel),
        .in_bcast(in_bcast), .in_valid(in_valid), .in_ready(in_ready),
        .out_a(out_a), .out_b(out_b), .out_c(out_c), .out_d(out_d),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    typedef struct {
        logic       rst_n;
        logic       valid;
        logic [1:0] sel;
        logic       bcast;
        logic [7:0] data;
        logic [3:0] ready;
        logic       chk_rdy;
        logic       exp_rdy;
        logic [3:0] exp_valid;
        logic [3:0] dmask;
        logic [31:0] exp_d;   // {d, c, b, a}
    } vec_t;

    vec_t vecs[$];

    function automatic logic [7:0] out_ch(input int i);
        case (i)
            0: return out_a;
            1: return out_b;
            2: return out_c;
            default: return out_d;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic r, input logic v, input logic [1:0] s, input logic b,
                       input logic [7:0] d, input logic [3:0] rdy, input logic crdy,
                       input logic erdy, input logic [3:0] ev, input logic [3:0] m,
                       input logic [31:0] ed);
        vec_t t;
        t.rst_n = r; t.valid = v; t.sel = s; t.bcast = b; t.data = d; t.ready = rdy;
        t.chk_rdy = crdy; t.exp_rdy = erdy; t.exp_valid = ev; t.dmask = m; t.exp_d = ed;
        vecs.push_back(t);
    endtask

    task automatic drive(input logic r, input logic v, input logic [1:0] s, input logic b,
                         input logic [7:0] d, input logic [3:0] rdy);
        rst_n = r; in_valid = v; in_sel = s; in_bcast = b; in_data = d; out_ready = rdy;
    endtask

    // Reference model state for the random phase
    logic [3:0] mv;
    logic [7:0] md [4];

    initial begin
        logic [31:0] ed;
        logic [3:0]  acc;
        logic        erdy, xfer, hold;
        logic [7:0]  tmp;

        drive(1'b1, 1'b0, 2'd0, 1'b0, 8'h00, 4'hf);

        // reset, steer
        add(0,0,0,0,8'h00,4'b1111, 0,0, 4'b0000, 4'b0000, 32'h0);
        add(0,0,0,0,8'h00,4'b1111, 0,0, 4'b0000, 4'b0001, 32'h0);
        add(1,1,3,0,8'h03,4'b1111, 1,1, 4'b1000, 4'b1000, 32'h03000000);
        add(1,1,0,0,8'hff,4'b1111, 1,1, 4'b0001, 4'b0001, 32'h000000ff);
        // backpressure on b
        add(1,1,1,0,8'h0f,4'b1101, 1,1, 4'b0010, 4'b0010, 32'h00000f00);
        add(1,1,1,0,8'hf0,4'b1101, 1,0, 4'b0010, 4'b0010, 32'h00000f00);
        add(1,1,1,0,8'hf0,4'b1101, 1,0, 4'b0010, 4'b0010, 32'h00000f00);
        add(1,1,1,0,8'hf0,4'b1111, 1,1, 4'b0010, 4'b0010, 32'h0000f000);
        // independent channels
        add(1,1,2,0,8'hc3,4'b1011, 1,1, 4'b0100, 4'b0100, 32'h00c30000);
        add(1,1,3,0,8'hee,4'b1011, 1,1, 4'b1100, 4'b1100, 32'heec30000);
        // broadcast blocked by a, then released
        add(1,1,0,0,8'h11,4'b1010, 1,1, 4'b0101, 4'b0101, 32'h00c30011);
        add(1,1,0,1,8'h5a,4'b1010, 1,0, 4'b0101, 4'b0101, 32'h00c30011);
        add(1,1,0,1,8'h5a,4'b1111, 1,1, 4'b1111, 4'b1111, 32'h5a5a5a5a);
        // streaming into c
        for (int k = 0; k < 8; k++) begin
            tmp = 8'(k);
            add(1,1,2,0,tmp,4'b1111, 1,1, 4'b0100, 4'b0100, {8'h00, tmp, 16'h0000});
        end
        // reset mid-operation with 1010 stalled
        add(1,1,1,0,8'haa,4'b0100, 1,1, 4'b0010, 4'b0010, 32'h0000aa00);
        add(1,1,3,0,8'hbb,4'b0000, 1,1, 4'b1010, 4'b1010, 32'hbb00aa00);
        add(0,1,0,0,8'hcc,4'b0000, 1,1, 4'b0000, 4'b1111, 32'h00000000);
        add(1,0,0,0,8'h00,4'b0000, 1,1, 4'b0000, 4'b1111, 32'h00000000);

        @(posedge clk); #1;
        foreach (vecs[n]) begin
            drive(vecs[n].rst_n, vecs[n].valid, vecs[n].sel, vecs[n].bcast,
                  vecs[n].data, vecs[n].ready);
            #1;
            if (vecs[n].chk_rdy)
                check($sformatf("vec%0d in_ready", n), 32'(in_ready), 32'(vecs[n].exp_rdy));
            @(posedge clk); #1;
            check($sformatf("vec%0d out_valid", n), 32'(out_valid), 32'(vecs[n].exp_valid));
            ed = vecs[n].exp_d;
            for (int i = 0; i < 4; i++) begin
                if (vecs[n].dmask[i])
                    check($sformatf("vec%0d data ch%0d", n, i), 32'(out_ch(i)),
                          32'((ed >> (8 * i)) & 32'hff));
            end
        end

        // Randomized phase: model starts from the post-reset state left by the table
        mv = 4'b0000;
        for (int i = 0; i < 4; i++) md[i] = 8'h00;
        hold = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (hold) begin
                out_ready = 4'($urandom);
                rst_n = ($urandom_range(0, 99) != 0);
            end else begin
                drive(($urandom_range(0, 49) != 0), ($urandom_range(0, 3) != 0),
                      2'($urandom), ($urandom_range(0, 7) == 0), 8'($urandom),
                      4'($urandom | $urandom));
            end
            #1;
            acc = ~mv | out_ready;
            erdy = in_bcast ? (acc == 4'b1111) : acc[in_sel];
            check("rand in_ready", 32'(in_ready), 32'(erdy));
            xfer = in_valid && erdy && rst_n;
            for (int i = 0; i < 4; i++) begin
                if (!rst_n) begin
                    mv[i] = 1'b0; md[i] = 8'h00;
                end else if (xfer && (in_bcast || in_sel == 2'(i))) begin
                    mv[i] = 1'b1; md[i] = in_data;
                end else if (out_ready[i]) begin
                    mv[i] = 1'b0;
                end
            end
            hold = rst_n && in_valid && !erdy;
            @(posedge clk); #1;
            check("rand out_valid", 32'(out_valid), 32'(mv));
            for (int i = 0; i < 4; i++) begin
                if (mv[i])
                    check($sformatf("rand data ch%0d", i), 32'(out_ch(i)), 32'(md[i]));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/four_output_demux_reg.md
Name: four_output_demux_reg

Overview:
- Registered 1-to-4 demultiplexer with valid/ready handshakes. It is the distribution counterpart of four_input_mux.
- It steers one input word to one of four output channels (a/b/c/d), or broadcasts it to all four.
- Each output channel has a one-entry output register, so every output is fully registered and each channel sustains one word per cycle.
- It sits between an operand/result source and multiple downstream ALU subunits.

Parameters:
- INPUT_LENGTH, 8, width of the data word on the input and on every output channel.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  synchronous reset, active-low.
- in_data  input  INPUT_LENGTH  word to route.
- in_sel  input  2  target channel: 0->a, 1->b, 2->c, 3->d (same select order as four_input_mux).
- in_bcast  input  1  1 = write word to all four channels; overrides in_sel.
- in_valid  input  1  in_data/in_sel/in_bcast valid this cycle.
- in_ready  output  1  block can accept this cycle (combinational).
- out_a, out_b, out_c, out_d  output  INPUT_LENGTH each  registered channel data.
- out_valid  output  4  per-channel valid; bit0=a, bit1=b, bit2=c, bit3=d.
- out_ready  input  4  per-channel downstream ready, same bit order.

Behaviour:
- Reset: on a rising edge with rst_n=0:
  - out_valid <= 4'b0000; out_a..out_d <= 0.
  - The input handshake is ignored that cycle; pending words are discarded, including during reset mid-transfer.
  - in_ready is not forced low, but no state changes while rst_n=0.
- Per-channel accept condition: can_acc[i] = !out_valid[i] || out_ready[i].
- in_ready (combinational, no dependence on in_valid):
  - in_bcast=1: AND of can_acc[3:0].
  - in_bcast=0: can_acc[in_sel].
- Transfer: occurs when in_valid && in_ready && rst_n.
- Load set: channel in_sel when in_bcast=0; all four channels when in_bcast=1.
- Per channel i, priority order each cycle:
  - i in load set and transfer: data[i] <= in_data, out_valid[i] <= 1.
  - else if out_valid[i] && out_ready[i]: out_valid[i] <= 0; data held.
  - else: hold.
- Latency: a word accepted in cycle N appears with out_valid=1 after the edge ending cycle N.
- Throughput: 1 word/cycle into the same channel when its out_ready is held high. A simultaneous drain and load keeps valid=1 and replaces the data.
- Backpressure:
  - While out_valid[i]=1 and out_ready[i]=0, data[i] is stable and out_valid[i] stays 1.
  - Any write targeting channel i stalls, with in_ready=0.
- Non-targeted channels are unaffected by a transfer: they drain or hold independently in the same cycle.
- Broadcast: all-or-nothing. It is never partially written; if any channel is blocked, nothing is loaded.
- Upstream obligation: hold in_data/in_sel/in_bcast stable while in_valid && !in_ready. The block does not latch the request, and a change re-evaluates in_ready.
- in_valid=0: no loads; channels only drain.
- out_ready on a channel with out_valid=0 has no effect.
- Data registers are not cleared on drain; their contents are don't-care while valid=0.
- No combinational path from in_data to any output. The only combinational paths are in_sel/in_bcast/out_ready/out_valid -> in_ready.

Test Plan:
- Reset then steer: rst_n=0 for 2 cycles, then rst_n=1, out_ready=4'b1111. Send in_sel=3, data 8'h03; then in_sel=0, 8'hff.
  -> out_valid=0 during reset; out_d=8'h03 with out_valid=4'b1000 one cycle later; next cycle out_a=8'hff, out_valid=4'b0001.
- Backpressure: out_ready[1]=0. Send 8'h0f to sel=1, then 8'hf0 to sel=1.
  -> first accepted; in_ready=0 for the second while out_valid[1]=1. Raise out_ready[1] -> 8'hf0 loads the same cycle, out_b=8'hf0, out_valid[1] stays 1.
- Independent channels: out_ready[2]=0 with a word in c. Send 8'hee to sel=3.
  -> accepted immediately; out_c held unchanged, out_d=8'hee.
- Broadcast: out_valid[0]=1, out_ready[0]=0. Send in_bcast=1 with 8'h5a.
  -> in_ready=0 and no channel changes. Release out_ready[0] -> all four outputs =8'h5a, out_valid=4'b1111 next cycle.
- Streaming: out_ready[2]=1. Send 8'h00..8'h07 back-to-back to sel=2.
  -> in_ready=1 every cycle; out_c shows 00..07 on consecutive cycles with no bubbles.
- Reset mid-operation: out_valid=4'b1010 stalled, in_valid=1. Pulse rst_n=0 one cycle.
  -> out_valid=4'b0000 next cycle; no load occurs in the reset cycle.
